// File: rtl/downsample_pkg.sv
// Shared constants and elaboration helpers for the binary-image block pooling path.
package downsample_pkg;

    localparam int MODE_DECIM  = 0;
    localparam int MODE_OR     = 1;
    localparam int MODE_THRESH = 2;

    // Ceiling log2, never below 1 so that every derived vector has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic bit params_ok(input int img_w, input int img_h, input int factor,
                                     input int mode, input int thresh);
        bit ok;
        ok = (factor >= 1);
        if (ok) ok = ((img_w % factor) == 0) && ((img_h % factor) == 0);
        if (ok) ok = (mode >= MODE_DECIM) && (mode <= MODE_THRESH);
        if (ok && mode == MODE_THRESH) ok = (thresh >= 1) && (thresh <= factor * factor);
        return ok;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One entry per output column: partial block count plus the stored top-left pixel.
module pool_line_buf #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 6,
    parameter int AW    = 5
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pool_downsample.sv
// Reduces each FACTOR x FACTOR block of a raster binary stream to one pixel
// (top-left decimation, OR pooling or count threshold), one cycle after the block completes.
module pool_downsample
    import downsample_pkg::*;
#(
    parameter int IMG_W  = 112,
    parameter int IMG_H  = 112,
    parameter int FACTOR = 4,
    parameter int MODE   = 0,
    parameter int THRESH = 8
) (
    input  logic                              sclk,
    input  logic                              s_rst,
    input  logic                              bin_data,
    input  logic                              bin_data_vld,
    input  logic                              bin_sof,
    output logic                              down_data,
    output logic                              down_data_vld,
    output logic [clog2(IMG_W/FACTOR)-1:0]    down_col,
    output logic [clog2(IMG_H/FACTOR)-1:0]    down_row,
    output logic                              down_eof
);

    localparam int CNT_W  = clog2(FACTOR * FACTOR + 1);
    localparam int COL_W  = clog2(IMG_W);
    localparam int ROW_W  = clog2(IMG_H);
    localparam int PH_W   = clog2(FACTOR);
    localparam int OCOL_W = clog2(IMG_W / FACTOR);
    localparam int OROW_W = clog2(IMG_H / FACTOR);
    localparam int ENT_W  = CNT_W + 1;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(FACTOR - 1);

    if (!params_ok(IMG_W, IMG_H, FACTOR, MODE, THRESH)) begin : g_param_err
        $error("pool_downsample: illegal IMG_W/IMG_H/FACTOR/MODE/THRESH combination");
    end

    function automatic logic reduce(input logic tl, input logic [CNT_W-1:0] cnt);
        case (MODE)
            MODE_DECIM: return tl;
            MODE_OR:    return (cnt != '0);
            default:    return (cnt >= CNT_W'(THRESH));
        endcase
    endfunction

    logic [COL_W-1:0]  r_in_col;
    logic [ROW_W-1:0]  r_in_row;
    logic [PH_W-1:0]   r_col_ph;
    logic [PH_W-1:0]   r_row_ph;
    logic [OCOL_W-1:0] r_ocol;
    logic [OROW_W-1:0] r_orow;
    logic [CNT_W-1:0]  r_seg_acc;
    logic              r_tl;
    logic              r_down_data;
    logic              r_down_vld;
    logic [OCOL_W-1:0] r_down_col;
    logic [OROW_W-1:0] r_down_row;
    logic              r_down_eof;

    // A start-of-frame pixel overrides the counters and is taken as position (0,0).
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic [PH_W-1:0]   w_col_ph;
    logic [PH_W-1:0]   w_row_ph;
    logic [OCOL_W-1:0] w_ocol;
    logic [OROW_W-1:0] w_orow;

    assign w_col    = bin_sof ? '0 : r_in_col;
    assign w_row    = bin_sof ? '0 : r_in_row;
    assign w_col_ph = bin_sof ? '0 : r_col_ph;
    assign w_row_ph = bin_sof ? '0 : r_row_ph;
    assign w_ocol   = bin_sof ? '0 : r_ocol;
    assign w_orow   = bin_sof ? '0 : r_orow;

    logic              w_last_col;
    logic              w_last_row;
    logic              w_seg_end;
    logic              w_emit;
    logic [CNT_W-1:0]  w_seg_sum;
    logic              w_tl;
    logic [ENT_W-1:0]  w_rd;
    logic [CNT_W-1:0]  w_cnt_new;
    logic              w_bit_new;

    assign w_last_col = (w_col == LAST_COL);
    assign w_last_row = (w_row == LAST_ROW);
    assign w_seg_end  = bin_data_vld && (w_col_ph == PH_LAST);
    assign w_emit     = w_seg_end && (w_row_ph == PH_LAST);
    assign w_seg_sum  = ((w_col_ph == '0) ? '0 : r_seg_acc) + CNT_W'(bin_data);
    assign w_tl       = (w_col_ph == '0) ? bin_data : r_tl;

    // Row phase 0 starts a fresh block column, so old buffer contents are ignored there.
    assign w_cnt_new  = ((w_row_ph == '0) ? '0 : w_rd[CNT_W-1:0]) + w_seg_sum;
    assign w_bit_new  = (w_row_ph == '0) ? w_tl : w_rd[CNT_W];

    pool_line_buf #(
        .DEPTH (IMG_W / FACTOR),
        .WIDTH (ENT_W),
        .AW    (OCOL_W)
    ) u_line_buf (
        .i_clk   (sclk),
        .i_we    (w_seg_end),
        .i_waddr (w_ocol),
        .i_wdata ({w_bit_new, w_cnt_new}),
        .i_raddr (w_ocol),
        .o_rdata (w_rd)
    );

    always_ff @(posedge sclk) begin
        if (bin_data_vld && (w_col_ph == '0)) r_tl <= bin_data;
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            r_in_col    <= '0;
            r_in_row    <= '0;
            r_col_ph    <= '0;
            r_row_ph    <= '0;
            r_ocol      <= '0;
            r_orow      <= '0;
            r_seg_acc   <= '0;
            r_down_data <= 1'b0;
            r_down_vld  <= 1'b0;
            r_down_col  <= '0;
            r_down_row  <= '0;
            r_down_eof  <= 1'b0;
        end else begin
            r_down_vld  <= w_emit;
            r_down_data <= w_emit && reduce(w_bit_new, w_cnt_new);
            r_down_eof  <= w_emit && w_last_col && w_last_row;
            if (w_emit) begin
                r_down_col <= w_ocol;
                r_down_row <= w_orow;
            end

            if (bin_data_vld) begin
                r_seg_acc <= w_seg_sum;
                if (w_last_col) begin
                    r_in_col <= '0;
                    r_col_ph <= '0;
                    r_ocol   <= '0;
                    if (w_last_row) begin
                        r_in_row <= '0;
                        r_row_ph <= '0;
                        r_orow   <= '0;
                    end else begin
                        r_in_row <= w_row + ROW_W'(1);
                        if (w_row_ph == PH_LAST) begin
                            r_row_ph <= '0;
                            r_orow   <= w_orow + OROW_W'(1);
                        end else begin
                            r_row_ph <= w_row_ph + PH_W'(1);
                            r_orow   <= w_orow;
                        end
                    end
                end else begin
                    r_in_col <= w_col + COL_W'(1);
                    r_in_row <= w_row;
                    r_row_ph <= w_row_ph;
                    r_orow   <= w_orow;
                    if (w_col_ph == PH_LAST) begin
                        r_col_ph <= '0;
                        r_ocol   <= w_ocol + OCOL_W'(1);
                    end else begin
                        r_col_ph <= w_col_ph + PH_W'(1);
                        r_ocol   <= w_ocol;
                    end
                end
            end
        end
    end

    assign down_data     = r_down_data;
    assign down_data_vld = r_down_vld;
    assign down_col      = r_down_col;
    assign down_row      = r_down_row;
    assign down_eof      = r_down_eof;

endmodule

// File: tb/tb_pool_downsample.sv
// Drives one binary stream into decimate, OR and threshold instances and compares each
// cycle against block sums taken from a stored copy of the transmitted image.
module tb_pool_downsample;

    localparam int W = 112;
    localparam int H = 112;
    localparam int F = 4;

    logic sclk = 1'b0;
    logic s_rst = 1'b1;
    logic bin_data = 1'b0;
    logic bin_data_vld = 1'b0;
    logic bin_sof = 1'b0;

    logic [2:0] dv;
    logic [2:0] dd;
    logic [2:0] de;
    logic [4:0] dc [3];
    logic [4:0] dr [3];

    always #5 sclk = ~sclk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pool_downsample #(
            .IMG_W  (W),
            .IMG_H  (H),
            .FACTOR (F),
            .MODE   (g),
            .THRESH (8)
        ) u_dut (
            .sclk          (sclk),
            .s_rst         (s_rst),
            .bin_data      (bin_data),
            .bin_data_vld  (bin_data_vld),
            .bin_sof       (bin_sof),
            .down_data     (dd[g]),
            .down_data_vld (dv[g]),
            .down_col      (dc[g]),
            .down_row      (dr[g]),
            .down_eof      (de[g])
        );
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    string t_vld [3] = '{"vld_m0", "vld_m1", "vld_m2"};
    string t_dat [3] = '{"data_m0", "data_m1", "data_m2"};
    string t_col [3] = '{"col_m0", "col_m1", "col_m2"};
    string t_row [3] = '{"row_m0", "row_m1", "row_m2"};
    string t_eof [3] = '{"eof_m0", "eof_m1", "eof_m2"};

    bit gen [H][W];
    bit img [H][W];
    int pos_r = 0;
    int pos_c = 0;
    int exp_vld = 0;
    int exp_data [3];
    int exp_col = 0;
    int exp_row = 0;
    int exp_eof = 0;

    int pulses = 0;
    int eofs   = 0;
    int ones1  = 0;
    int t00    = -1;
    int t01    = -1;

    task automatic clear_stats();
        pulses = 0;
        eofs   = 0;
        ones1  = 0;
        t00    = -1;
        t01    = -1;
    endtask

    // kind 0: checkerboard, 1: single set pixel at (5,9), 2: random with fixed first two blocks
    task automatic fill_gen(input int kind);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (kind)
                    0:       gen[r][c] = (((r + c) % 2) == 1);
                    1:       gen[r][c] = (r == 5) && (c == 9);
                    default: gen[r][c] = ($urandom_range(1) == 1);
                endcase
            end
        end
        if (kind == 2) begin
            for (int r = 0; r < F; r++) begin
                for (int c = 0; c < F; c++) begin
                    gen[r][c]     = (r < 2);
                    gen[r][c + F] = ((r * F + c) < 7);
                end
            end
        end
    endtask

    // One clock: check outputs caused by the previous cycle's input, then drive this cycle.
    task automatic tick(input bit v, input bit d, input bit s);
        int sum;
        @(posedge sclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq(t_vld[i], int'(dv[i]), exp_vld);
            if (exp_vld != 0) begin
                check_eq(t_dat[i], int'(dd[i]), exp_data[i]);
                check_eq(t_col[i], int'(dc[i]), exp_col);
                check_eq(t_row[i], int'(dr[i]), exp_row);
                check_eq(t_eof[i], int'(de[i]), exp_eof);
            end else begin
                check_eq(t_dat[i], int'(dd[i]), 0);
                check_eq(t_eof[i], int'(de[i]), 0);
            end
        end
        if (dv[0]) pulses++;
        if (dv[0] && de[0]) eofs++;
        if (dv[1] && dd[1]) ones1++;
        if (dv[2] && dr[2] == 5'd0 && dc[2] == 5'd0) t00 = int'(dd[2]);
        if (dv[2] && dr[2] == 5'd0 && dc[2] == 5'd1) t01 = int'(dd[2]);

        bin_data_vld = v;
        bin_data     = d;
        bin_sof      = s;

        exp_vld = 0;
        if (v) begin
            if (s) begin
                pos_r = 0;
                pos_c = 0;
            end
            img[pos_r][pos_c] = d;
            if ((pos_r % F) == F - 1 && (pos_c % F) == F - 1) begin
                sum = 0;
                for (int r = pos_r - F + 1; r <= pos_r; r++)
                    for (int c = pos_c - F + 1; c <= pos_c; c++)
                        sum += int'(img[r][c]);
                exp_vld     = 1;
                exp_data[0] = int'(img[pos_r - F + 1][pos_c - F + 1]);
                exp_data[1] = (sum != 0) ? 1 : 0;
                exp_data[2] = (sum >= 8) ? 1 : 0;
                exp_col     = pos_c / F;
                exp_row     = pos_r / F;
                exp_eof     = (pos_r == H - 1 && pos_c == W - 1) ? 1 : 0;
            end
            if (pos_c == W - 1) begin
                pos_c = 0;
                pos_r = (pos_r == H - 1) ? 0 : pos_r + 1;
            end else begin
                pos_c++;
            end
        end
    endtask

    task automatic send_pixels(input int npix, input int gap_pct);
        for (int k = 0; k < npix; k++) begin
            while (int'($urandom_range(99)) < gap_pct)
                tick(1'b0, ($urandom_range(1) == 1), ($urandom_range(1) == 1));
            tick(1'b1, gen[k / W][k % W], (k == 0));
        end
    endtask

    task automatic do_reset();
        @(posedge sclk);
        #1;
        bin_data_vld = 1'b0;
        bin_sof      = 1'b0;
        s_rst        = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            check_eq(t_vld[i], int'(dv[i]), 0);
            check_eq(t_dat[i], int'(dd[i]), 0);
            check_eq(t_col[i], int'(dc[i]), 0);
            check_eq(t_row[i], int'(dr[i]), 0);
            check_eq(t_eof[i], int'(de[i]), 0);
        end
        s_rst   = 1'b0;
        exp_vld = 0;
        pos_r   = 0;
        pos_c   = 0;
    endtask

    initial begin
        repeat (3) @(posedge sclk);
        do_reset();

        // Checkerboard, decimation picks only even-parity pixels.
        fill_gen(0);
        clear_stats();
        send_pixels(W * H, 0);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("pulses_checker", pulses, 784);
        check_eq("eof_checker", eofs, 1);

        // Single set pixel with heavy input gaps.
        fill_gen(1);
        clear_stats();
        send_pixels(W * H, 50);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("or_ones_single", ones1, 1);
        check_eq("pulses_gapped", pulses, 784);

        // Reset mid-frame at input (50,30), then a fresh frame.
        fill_gen(2);
        send_pixels(50 * W + 30, 0);
        do_reset();
        fill_gen(2);
        clear_stats();
        send_pixels(W * H, 10);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("thresh_blk00", t00, 1);
        check_eq("thresh_blk01", t01, 0);
        check_eq("pulses_after_rst", pulses, 784);
        check_eq("eof_after_rst", eofs, 1);

        // Start of frame arriving at input (3,0) abandons the partial frame.
        fill_gen(2);
        clear_stats();
        send_pixels(3 * W, 0);
        check_eq("pulses_abandoned", pulses, 0);
        fill_gen(2);
        clear_stats();
        send_pixels(W * H, 0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("pulses_after_sof", pulses, 784);
        check_eq("eof_after_sof", eofs, 1);
        check_eq("thresh_blk00_sof", t00, 1);
        check_eq("thresh_blk01_sof", t01, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
